multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle sequencer for the MIPS-subset datapath. It replaces the single-cycle Control_Unit decode with a Moore FSM that drives PC, IR, memory, register-file and ALU-mux controls state by state.
- Supported instructions: add, sub, and, or, xor, lw, sw, beq, lui.
- Memory accesses wait on a ready handshake.
- Retired instructions are counted for CPI measurement.

Parameters:
- CNT_W, 32, width of retired-instruction counter instr_cnt.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]
- func  in  6  IR[5:0]
- mem_ready  in  1  memory completes current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- IRWrite  out  1  load IR (and MDR)
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- MemtoReg  out  1  writeback source: 0=ALUOut, 1=MDR
- RegDst  out  1  dest: 0=rt, 1=rd
- RegWrite  out  1  register-file write
- ALUSrcA  out  1  0=PC, 1=regA
- ALUSrcB  out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
- PCSource  out  2  00=ALU result, 01=ALUOut
- ALU_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LUI (imm<<16)
- retire  out  1  one-cycle pulse in final state of each instruction
- illegal  out  1  sticky: undecodable op/func seen
- state  out  4  current state, for debug
- instr_cnt  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- Reset:
  - On clk edge with rst=1: state=FETCH (0), instr_cnt=0, illegal=0.
  - While rst=1, all strobes (PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite, retire) are forced 0.
  - Reset mid-instruction aborts it with no writes.
- Outputs are combinational from the registered state. The only Mealy exceptions are qualifiers on mem_ready. Unlisted outputs are 0 in each state.
- States and actions:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=ADD, PCSource=00, IRWrite=PCWrite=mem_ready. Go to DECODE when mem_ready, else stay.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALU_op=ADD (branch target into ALUOut).
    - op=000000 with a legal func -> R_EX.
    - op 100011 or 101011 -> MEM_ADDR.
    - op 000100 -> BRANCH.
    - op 001111 -> LUI_EX.
    - Anything else, including op=0 with an unlisted func -> TRAP.
  - MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALU_op=ADD. lw -> MEM_RD, sw -> MEM_WR.
  - MEM_RD(3): MemRead=1, IorD=1, IRWrite=0 (MDR loads). -> MEM_WB when mem_ready, else stay.
  - MEM_WB(4): RegWrite=1, MemtoReg=1, RegDst=0, retire=1. -> FETCH.
  - MEM_WR(5): MemWrite=1, IorD=1, retire=mem_ready. -> FETCH when mem_ready, else stay.
  - R_EX(6): ALUSrcA=1, ALUSrcB=00. ALU_op from func: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR. -> R_WB.
  - R_WB(7): RegWrite=1, RegDst=1, MemtoReg=0, retire=1. -> FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALU_op=SUB, PCWriteCond=1, PCSource=01, retire=1. -> FETCH.
  - LUI_EX(9): ALUSrcB=10, ALU_op=LUI. -> LUI_WB.
  - LUI_WB(10): RegWrite=1, RegDst=0, MemtoReg=0, retire=1. -> FETCH.
  - TRAP(11): illegal=1 (sticky), all strobes 0. Stays in TRAP until rst.
  - Codes 12-15 are unreachable; if entered, go to TRAP.
- Latency with mem_ready held at 1:
  - lw 5 cycles; R-type, sw and lui 4 cycles; beq 3 cycles.
  - Each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- instr_cnt increments on every cycle with retire=1. It wraps from all-ones to 0.
- op and func must be stable from DECODE through the instruction's final state. The datapath IR guarantees this.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings (FETCH..TRAP)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_LUI)
  - func constants (add, sub, and, or, xor)
  - ALU_op encodings
  - ALUSrcB and PCSource encodings
- One sub-module, alu_func_decode: combinational func -> {ALU_op, legal}. It is reused by DECODE for legality and by R_EX for ALU_op.

Test Plan:
- rst=1 for 2 cycles, then op=0, func=100000, mem_ready=1 -> states 0,1,6,7,0. R_EX has ALU_op=000. R_WB has RegWrite=1, RegDst=1, retire=1. instr_cnt=1.
- lw (op=100011), mem_ready low for 2 cycles in MEM_RD -> MEM_RD held 3 cycles with MemRead=1, IorD=1. Then MEM_WB has RegWrite=1, MemtoReg=1. Total 7 cycles.
- sw (101011), then beq (000100), then lui (001111), mem_ready=1:
  - sw asserts MemWrite in state 5 for one cycle.
  - beq shows PCWriteCond=1, PCSource=01, ALU_op=001 in state 8.
  - lui shows ALU_op=101 in state 9.
  - instr_cnt advances by 3 over 11 cycles.
- op=0, func=101010 (slt, unsupported) -> DECODE goes to TRAP. illegal=1 is held and all strobes stay 0 for 20 cycles. rst clears illegal and returns to FETCH.
- FETCH with mem_ready=0 for 5 cycles -> IRWrite=PCWrite=0 throughout. Both pulse for exactly one cycle when mem_ready=1.
- rst asserted during MEM_WR with mem_ready=0 -> no MemWrite pulse at the following edge. state=0, instr_cnt=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller:
// states, opcodes, R-type func codes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_LUI_EX   = 4'd9,
        S_LUI_WB   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_LUI = 3'b101
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath bundle: IR fields and mem_ready in, control strobes out.
interface multicycle_ctrl_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       func;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             IRWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       PCSource;
    logic [2:0]       ALU_op;
    logic             retire;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  op, func, mem_ready,
        output PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               ALU_op, retire, illegal, state, instr_cnt
    );

    modport slave (
        output op, func, mem_ready,
        input  PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               ALU_op, retire, illegal, state, instr_cnt
    );
endinterface

// File: rtl/alu_func_decode.sv
// R-type func field to ALU operation, with a legality flag for the supported subset.
module alu_func_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_func,
    output alu_op_t    o_alu_op,
    output logic       o_legal
);
    always_comb begin
        o_alu_op = ALU_ADD;
        o_legal  = 1'b1;
        case (i_func)
            FN_ADD:  o_alu_op = ALU_ADD;
            FN_SUB:  o_alu_op = ALU_SUB;
            FN_AND:  o_alu_op = ALU_AND;
            FN_OR:   o_alu_op = ALU_OR;
            FN_XOR:  o_alu_op = ALU_XOR;
            default: o_legal  = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore sequencer for the multi-cycle MIPS-subset datapath; mem_ready only
// qualifies the fetch/store strobes. Counts retired instructions.
module multicycle_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic                   clk,
    input logic                   rst,
    multicycle_ctrl_fsm_if.master bus
);
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_illegal;

    state_t     w_next;
    alu_op_t    w_fn_op;
    logic       w_fn_legal;
    logic       w_pcwrite, w_pcwritecond, w_iord, w_irwrite, w_memread;
    logic       w_memwrite, w_memtoreg, w_regdst, w_regwrite, w_alusrca;
    logic       w_retire;
    logic [1:0] w_alusrcb, w_pcsource;
    alu_op_t    w_alu_op;

    alu_func_decode u_fn_dec (
        .i_func   (bus.func),
        .o_alu_op (w_fn_op),
        .o_legal  (w_fn_legal)
    );

    always_comb begin
        w_next        = r_state;
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_iord        = 1'b0;
        w_irwrite     = 1'b0;
        w_memread     = 1'b0;
        w_memwrite    = 1'b0;
        w_memtoreg    = 1'b0;
        w_regdst      = 1'b0;
        w_regwrite    = 1'b0;
        w_alusrca     = 1'b0;
        w_retire      = 1'b0;
        w_alusrcb     = SRCB_REGB;
        w_pcsource    = PCSRC_ALU;
        w_alu_op      = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                w_alusrcb = SRCB_FOUR;
                w_irwrite = bus.mem_ready;
                w_pcwrite = bus.mem_ready;
                if (bus.mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_alusrcb = SRCB_IMM_SH2;
                case (bus.op)
                    OP_RTYPE:     w_next = w_fn_legal ? S_R_EX : S_TRAP;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_LUI:       w_next = S_LUI_EX;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                w_alusrca = 1'b1;
                w_alusrcb = SRCB_IMM;
                w_next    = (bus.op == OP_LW) ? S_MEM_RD :
                            (bus.op == OP_SW) ? S_MEM_WR : S_TRAP;
            end
            S_MEM_RD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
                if (bus.mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
                w_retire   = bus.mem_ready;
                if (bus.mem_ready) w_next = S_FETCH;
            end
            S_R_EX: begin
                w_alusrca = 1'b1;
                w_alu_op  = w_fn_op;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                w_regwrite = 1'b1;
                w_regdst   = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                w_alusrca     = 1'b1;
                w_alu_op      = ALU_SUB;
                w_pcwritecond = 1'b1;
                w_pcsource    = PCSRC_ALUOUT;
                w_retire      = 1'b1;
                w_next        = S_FETCH;
            end
            S_LUI_EX: begin
                w_alusrcb = SRCB_IMM;
                w_alu_op  = ALU_LUI;
                w_next    = S_LUI_WB;
            end
            S_LUI_WB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
            // set on entry so the flag is already high in the first TRAP cycle
            if (w_next == S_TRAP) r_illegal <= 1'b1;
        end
    end

    assign bus.PCWrite     = w_pcwrite     & ~rst;
    assign bus.PCWriteCond = w_pcwritecond & ~rst;
    assign bus.IRWrite     = w_irwrite     & ~rst;
    assign bus.MemRead     = w_memread     & ~rst;
    assign bus.MemWrite    = w_memwrite    & ~rst;
    assign bus.RegWrite    = w_regwrite    & ~rst;
    assign bus.retire      = w_retire      & ~rst;
    assign bus.IorD        = w_iord;
    assign bus.MemtoReg    = w_memtoreg;
    assign bus.RegDst      = w_regdst;
    assign bus.ALUSrcA     = w_alusrca;
    assign bus.ALUSrcB     = w_alusrcb;
    assign bus.PCSource    = w_pcsource;
    assign bus.ALU_op      = w_alu_op;
    assign bus.illegal     = r_illegal;
    assign bus.state       = r_state;
    assign bus.instr_cnt   = r_cnt;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed vector bench for the multi-cycle controller, plus counter wrap on a narrow instance.
module tb_multicycle_ctrl_fsm;
    logic clk;
    logic rst;
    logic rst2;

    multicycle_ctrl_fsm_if #(.CNT_W(32)) bus ();
    multicycle_ctrl_fsm_if #(.CNT_W(2))  bus2 ();

    multicycle_ctrl_fsm #(.CNT_W(32)) u_dut  (.clk(clk), .rst(rst),  .bus(bus));
    multicycle_ctrl_fsm #(.CNT_W(2))  u_dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,IRWrite,MemRead,MemWrite,MemtoReg,RegDst,
    //  RegWrite,ALUSrcA,ALUSrcB[1:0],PCSource[1:0],ALU_op[2:0],retire,illegal}
    logic [18:0] w_ctl;
    assign w_ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.IRWrite,
                    bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.RegDst,
                    bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource,
                    bus.ALU_op, bus.retire, bus.illegal};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  func;
        logic        mr;
        logic [3:0]  st;
        logic [18:0] ctl;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    logic [18:0] C_FR, C_FN, C_DEC, C_MADDR, C_MRD, C_MWB, C_MWR_R, C_MWR_N, C_MWR_RST;
    logic [18:0] C_REX_ADD, C_REX_SUB, C_REX_AND, C_REX_OR, C_REX_XOR, C_RWB;
    logic [18:0] C_BR, C_LUIEX, C_LUIWB, C_TRAP;

    function automatic logic [18:0] mk(
        input logic pcw, pcwc, iord, irw, mr, mw, m2r, rd, rw, sa,
        input logic [1:0] sb, ps, input logic [2:0] aop, input logic ret, ill);
        return {pcw, pcwc, iord, irw, mr, mw, m2r, rd, rw, sa, sb, ps, aop, ret, ill};
    endfunction

    task automatic add(input logic r, input logic [5:0] op, fn, input logic mr,
                       input logic [3:0] st, input logic [18:0] ctl, input logic [31:0] cnt);
        tbl.push_back('{r, op, fn, mr, st, ctl, cnt});
    endtask

    task automatic add_rtype(input logic [5:0] fn, input logic [18:0] rex, input logic [31:0] cnt);
        add(0, 6'h00, fn, 1, 4'd0, C_FR,  cnt);
        add(0, 6'h00, fn, 1, 4'd1, C_DEC, cnt);
        add(0, 6'h00, fn, 1, 4'd6, rex,   cnt);
        add(0, 6'h00, fn, 1, 4'd7, C_RWB, cnt);
    endtask

    task automatic step(input logic r, input logic [5:0] op, fn, input logic mr,
                        input logic [3:0] st, input logic [18:0] ctl, input logic [31:0] cnt);
        @(negedge clk);
        rst = r; bus.op = op; bus.func = fn; bus.mem_ready = mr;
        #1;
        n_vec++;
        if (bus.state !== st) begin
            n_miss++;
            $display("FAIL vec%0d state got %0d want %0d", n_vec, bus.state, st);
        end
        if (w_ctl !== ctl) begin
            n_miss++;
            $display("FAIL vec%0d ctl got %b want %b", n_vec, w_ctl, ctl);
        end
        if (bus.instr_cnt !== cnt) begin
            n_miss++;
            $display("FAIL vec%0d instr_cnt got %0d want %0d", n_vec, bus.instr_cnt, cnt);
        end
    endtask

    initial begin
        //               pcw pcwc iord irw mr mw m2r rd rw sa  sb     ps     aop    ret ill
        C_FR      = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0, 0);
        C_FN      = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0, 0);
        C_DEC     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b000, 0, 0);
        C_MADDR   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b000, 0, 0);
        C_MRD     = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
        C_MWB     = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 1, 0);
        C_MWR_R   = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 0);
        C_MWR_N   = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
        C_MWR_RST = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
        C_REX_ADD = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 0, 0);
        C_REX_SUB = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b001, 0, 0);
        C_REX_AND = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 0, 0);
        C_REX_OR  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b011, 0, 0);
        C_REX_XOR = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b100, 0, 0);
        C_RWB     = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b000, 1, 0);
        C_BR      = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b001, 1, 0);
        C_LUIEX   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3'b101, 0, 0);
        C_LUIWB   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 1, 0);
        C_TRAP    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 1);

        // add: 0,1,6,7
        add_rtype(6'b100000, C_REX_ADD, 0);
        // lw with two wait cycles in MEM_RD
        add(0, 6'h23, 6'h00, 1, 4'd0, C_FR,    1);
        add(0, 6'h23, 6'h00, 1, 4'd1, C_DEC,   1);
        add(0, 6'h23, 6'h00, 1, 4'd2, C_MADDR, 1);
        add(0, 6'h23, 6'h00, 0, 4'd3, C_MRD,   1);
        add(0, 6'h23, 6'h00, 0, 4'd3, C_MRD,   1);
        add(0, 6'h23, 6'h00, 1, 4'd3, C_MRD,   1);
        add(0, 6'h23, 6'h00, 1, 4'd4, C_MWB,   1);
        // sw, beq, lui back to back
        add(0, 6'h2B, 6'h00, 1, 4'd0, C_FR,    2);
        add(0, 6'h2B, 6'h00, 1, 4'd1, C_DEC,   2);
        add(0, 6'h2B, 6'h00, 1, 4'd2, C_MADDR, 2);
        add(0, 6'h2B, 6'h00, 1, 4'd5, C_MWR_R, 2);
        add(0, 6'h04, 6'h00, 1, 4'd0, C_FR,    3);
        add(0, 6'h04, 6'h00, 1, 4'd1, C_DEC,   3);
        add(0, 6'h04, 6'h00, 1, 4'd8, C_BR,    3);
        add(0, 6'h0F, 6'h00, 1, 4'd0, C_FR,    4);
        add(0, 6'h0F, 6'h00, 1, 4'd1, C_DEC,   4);
        add(0, 6'h0F, 6'h00, 1, 4'd9, C_LUIEX, 4);
        add(0, 6'h0F, 6'h00, 1, 4'd10, C_LUIWB, 4);
        // remaining R-type funcs
        add_rtype(6'b100010, C_REX_SUB, 5);
        add_rtype(6'b100100, C_REX_AND, 6);
        add_rtype(6'b100101, C_REX_OR,  7);
        add_rtype(6'b100110, C_REX_XOR, 8);
        // fetch stalled five cycles
        for (int i = 0; i < 5; i++) add(0, 6'h00, 6'h20, 0, 4'd0, C_FN, 9);
        add_rtype(6'b100000, C_REX_ADD, 9);
        // sw stalled in MEM_WR, then reset mid-store
        add(0, 6'h2B, 6'h00, 1, 4'd0, C_FR,      10);
        add(0, 6'h2B, 6'h00, 1, 4'd1, C_DEC,     10);
        add(0, 6'h2B, 6'h00, 1, 4'd2, C_MADDR,   10);
        add(0, 6'h2B, 6'h00, 0, 4'd5, C_MWR_N,   10);
        add(1, 6'h2B, 6'h00, 0, 4'd5, C_MWR_RST, 10);
        add(0, 6'h00, 6'h20, 1, 4'd0, C_FR,      0);

        rst = 1'b1; rst2 = 1'b1;
        bus.op = '0; bus.func = '0; bus.mem_ready = 1'b1;
        bus2.op = 6'h04; bus2.func = '0; bus2.mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) step(tbl[i].rst, tbl[i].op, tbl[i].func, tbl[i].mr,
                              tbl[i].st, tbl[i].ctl, tbl[i].cnt);

        // unsupported func (slt) traps and stays trapped whatever mem_ready does
        step(0, 6'h00, 6'h2A, 1, 4'd1, C_DEC, 0);
        for (int i = 0; i < 20; i++) step(0, 6'h00, 6'h2A, i[0], 4'd11, C_TRAP, 0);
        step(1, 6'h00, 6'h2A, 1, 4'd11, C_TRAP, 0);
        step(0, 6'h02, 6'h00, 1, 4'd0, C_FR, 0);
        // unknown opcode (j) also traps
        step(0, 6'h02, 6'h00, 1, 4'd1, C_DEC, 0);
        step(0, 6'h02, 6'h00, 1, 4'd11, C_TRAP, 0);
        step(1, 6'h00, 6'h00, 1, 4'd11, C_TRAP, 0);
        step(0, 6'h00, 6'h20, 1, 4'd0, C_FR, 0);

        // 2-bit counter wraps after four beq instructions
        @(negedge clk);
        rst2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] want;
            want = 2'((k + 1) % 4);
            repeat (3) @(negedge clk);
            #1;
            n_vec++;
            if (bus2.instr_cnt !== want || bus2.state !== 4'd0) begin
                n_miss++;
                $display("FAIL wrap%0d cnt/state got %0d/%0d want %0d/0",
                         k, bus2.instr_cnt, bus2.state, want);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
